// File: rtl/cc_poscomp_pkg.sv
// cc_poscomp_pkg: shared channel state encoding and compare-mode constants.
package cc_poscomp_pkg;
  typedef enum logic [1:0] {
    NO_HIT   = 2'b00,
    HIT_NEW  = 2'b01,
    HIT_HELD = 2'b10
  } state_e;
  localparam int CMP_EXACT   = 0;
  localparam int CMP_OVERLAP = 1;
endpackage

// File: rtl/cc_poscomp_channel.sv
// cc_poscomp_channel: one player's match, collision FSM and optional saturating hit counter.
// The counter exists only when POSCOMP_HITCOUNT_EN is defined.
module cc_poscomp_channel
  import cc_poscomp_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int CNT_WIDTH    = 4,
  parameter int COMPARE_MODE = CMP_EXACT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATAWIDTH-1:0] fila_i,
  input  logic [DATAWIDTH-1:0] pos_i,
  input  logic                 sample_i,
  input  logic                 clear_i,
  output logic                 hit_o,
  output logic                 event_o
`ifdef POSCOMP_HITCOUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] count_o
`endif
);
  state_e state_q, state_d;
  logic   event_q, event_d, match;
  // An all-zero position means the player is absent and can never collide.
  assign match = (|pos_i) && (COMPARE_MODE == CMP_OVERLAP ? |(pos_i & fila_i) : pos_i == fila_i);
  always_comb begin
    state_d = state_q;
    event_d = 1'b0;
    if (clear_i) state_d = NO_HIT;
    else if (sample_i) begin
      state_d = !match ? NO_HIT : (state_q == NO_HIT ? HIT_NEW : HIT_HELD);
      event_d = match && state_q == NO_HIT;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= NO_HIT;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      event_q <= event_d;
    end
  end
  assign hit_o   = state_q != NO_HIT;
  assign event_o = event_q;
`ifdef POSCOMP_HITCOUNT_EN
  logic [CNT_WIDTH-1:0] count_q, count_d;
  assign count_d = (event_d && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) count_q <= '0;
    else count_q <= count_d;
  end
  assign count_o = count_q;
`endif
endmodule

// File: rtl/cc_poscomparator_multi.sv
// cc_poscomparator_multi: per-player obstacle-row collision detector with sample strobe and clear.
// Define POSCOMP_HITCOUNT_EN to add the per-player saturating hit counters and count port.
module cc_poscomparator_multi
  import cc_poscomp_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int NUM_PLAYERS  = 2,
  parameter int CNT_WIDTH    = 4,
  parameter int COMPARE_MODE = CMP_EXACT
) (
  input  logic                             CC_POSCOMP_CLOCK_50,
  input  logic                             CC_POSCOMP_RESET_InLow,
  input  logic [DATAWIDTH-1:0]             CC_POSCOMP_fila_InBUS,
  input  logic [NUM_PLAYERS*DATAWIDTH-1:0] CC_POSCOMP_pos_InBUS,
  input  logic                             CC_POSCOMP_sample_In,
  input  logic                             CC_POSCOMP_clear_In,
  output logic [NUM_PLAYERS-1:0]           CC_POSCOMP_hit_OutBUS,
  output logic [NUM_PLAYERS-1:0]           CC_POSCOMP_event_OutBUS,
  output logic                             CC_POSCOMP_any_Out,
  output logic                             CC_POSCOMP_valid_Out
`ifdef POSCOMP_HITCOUNT_EN
  ,
  output logic [NUM_PLAYERS*CNT_WIDTH-1:0] CC_POSCOMP_count_OutBUS
`endif
);
  logic valid_q;
  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8 || CNT_WIDTH < 1) begin : g_bad_cfg
    $error("cc_poscomparator_multi: NUM_PLAYERS must be 1..8 and CNT_WIDTH >= 1");
  end
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
    cc_poscomp_channel #(
      .DATAWIDTH(DATAWIDTH),
      .CNT_WIDTH(CNT_WIDTH),
      .COMPARE_MODE(COMPARE_MODE)
    ) u_ch (
      .clk_i(CC_POSCOMP_CLOCK_50),
      .rst_ni(CC_POSCOMP_RESET_InLow),
      .fila_i(CC_POSCOMP_fila_InBUS),
      .pos_i(CC_POSCOMP_pos_InBUS[p*DATAWIDTH +: DATAWIDTH]),
      .sample_i(CC_POSCOMP_sample_In),
      .clear_i(CC_POSCOMP_clear_In),
      .hit_o(CC_POSCOMP_hit_OutBUS[p]),
      .event_o(CC_POSCOMP_event_OutBUS[p])
`ifdef POSCOMP_HITCOUNT_EN
      ,
      .count_o(CC_POSCOMP_count_OutBUS[p*CNT_WIDTH +: CNT_WIDTH])
`endif
    );
  end
  // Hit bits come straight from state flops, so the OR updates on the same edge.
  assign CC_POSCOMP_any_Out = |CC_POSCOMP_hit_OutBUS;
  always_ff @(posedge CC_POSCOMP_CLOCK_50) begin
    valid_q <= CC_POSCOMP_RESET_InLow && CC_POSCOMP_sample_In && !CC_POSCOMP_clear_In;
  end
  assign CC_POSCOMP_valid_Out = valid_q;
endmodule

// File: tb/tb_cc_poscomparator_multi.sv
// tb_cc_poscomparator_multi: randomized and directed checks of an exact-mode and an overlap-mode instance against a frame-level model.
module tb_cc_poscomparator_multi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  fila = '0;
  logic [15:0] pos = '0;
  logic        sample = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  h0, e0, h1, e1;
  logic        a0, v0, a1, v1;
  int          n = 0;
  int          nf = 0;
  bit          mh[2][2], me[2][2];
  bit          mv;
  int          mc[2][2];
`ifdef POSCOMP_HITCOUNT_EN
  logic [3:0]  c0;
  logic [7:0]  c1;
`endif

  always #5 clk = ~clk;

  cc_poscomparator_multi #(.COMPARE_MODE(0), .CNT_WIDTH(2)) dut0 (
    .CC_POSCOMP_CLOCK_50(clk), .CC_POSCOMP_RESET_InLow(rst_n),
    .CC_POSCOMP_fila_InBUS(fila), .CC_POSCOMP_pos_InBUS(pos),
    .CC_POSCOMP_sample_In(sample), .CC_POSCOMP_clear_In(clear),
    .CC_POSCOMP_hit_OutBUS(h0), .CC_POSCOMP_event_OutBUS(e0),
    .CC_POSCOMP_any_Out(a0), .CC_POSCOMP_valid_Out(v0)
`ifdef POSCOMP_HITCOUNT_EN
    , .CC_POSCOMP_count_OutBUS(c0)
`endif
  );

  cc_poscomparator_multi #(.COMPARE_MODE(1)) dut1 (
    .CC_POSCOMP_CLOCK_50(clk), .CC_POSCOMP_RESET_InLow(rst_n),
    .CC_POSCOMP_fila_InBUS(fila), .CC_POSCOMP_pos_InBUS(pos),
    .CC_POSCOMP_sample_In(sample), .CC_POSCOMP_clear_In(clear),
    .CC_POSCOMP_hit_OutBUS(h1), .CC_POSCOMP_event_OutBUS(e1),
    .CC_POSCOMP_any_Out(a1), .CC_POSCOMP_valid_Out(v1)
`ifdef POSCOMP_HITCOUNT_EN
    , .CC_POSCOMP_count_OutBUS(c1)
`endif
  );

  // A collision is "the player overlaps the row at this sample"; an event is a collision not present at the previous accepted sample.
  function automatic bit collides(int mode, logic [7:0] f, logic [7:0] p);
    if (p == 0) return 0;
    return mode == 1 ? ((p & f) != 0) : (p == f);
  endfunction

  function automatic logic [5:0] ex(int d);
    return {mh[d][1], mh[d][0], me[d][1], me[d][0], mh[d][0] | mh[d][1], mv};
  endfunction

  function automatic logic [7:0] ex_cnt(int d);
    return d == 0 ? 8'({mc[0][1][1:0], mc[0][0][1:0]}) : 8'({mc[1][1][3:0], mc[1][0][3:0]});
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        bit m;
        m = collides(d, fila, pos[p*8 +: 8]);
        if (!rst_n || clear) begin
          mh[d][p] = 0; me[d][p] = 0; mc[d][p] = 0;
        end else if (sample) begin
          me[d][p] = m && !mh[d][p];
          if (me[d][p] && mc[d][p] < (d == 0 ? 3 : 15)) mc[d][p]++;
          mh[d][p] = m;
        end else me[d][p] = 0;
      end
    mv = rst_n && sample && !clear;
    #1;
  endtask

  task automatic drive(bit r, bit s, bit c, logic [7:0] f, logic [15:0] p);
    rst_n = r; sample = s; clear = c; fila = f; pos = p;
  endtask

  task automatic test_reset();
    drive(0, 1, 0, 8'h10, 16'h0410);
    tick();
    n++;
    if ({h0, e0, a0, v0, h1, e1, a1, v1} !== 12'h000) begin
      nf++; $display("FAIL reset_outputs got %b want %b", {h0, e0, a0, v0, h1, e1, a1, v1}, 12'h000);
    end
    drive(1, 0, 0, 8'h10, 16'h0410);
    tick();
    n++;
    if ({h0, e0, a0, v0} !== 6'b0) begin
      nf++; $display("FAIL reset_release got %b want %b", {h0, e0, a0, v0}, 6'b0);
    end
  endtask

  task automatic test_exact_match();
    drive(1, 1, 0, 8'h10, 16'h0410);
    tick();
    n++;
    if ({h0, e0, a0, v0} !== 6'b01_01_1_1) begin
      nf++; $display("FAIL exact_first_hit got %b want %b", {h0, e0, a0, v0}, 6'b01_01_1_1);
    end
    drive(1, 0, 0, 8'h10, 16'h0410);
    tick();
    n++;
    if ({h0, e0, a0, v0} !== 6'b01_00_1_0) begin
      nf++; $display("FAIL exact_hold_between got %b want %b", {h0, e0, a0, v0}, 6'b01_00_1_0);
    end
  endtask

  task automatic test_held();
    int evs = 0;
    drive(1, 0, 1, 8'h10, 16'h0410);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 8'h10, 16'h0410);
      tick();
      evs += int'(e0[0]);
      n++;
      if (h0 !== 2'b01) begin
        nf++; $display("FAIL held_hit sample %0d got %b want %b", k, h0, 2'b01);
      end
    end
    n++;
    if (evs != 1) begin
      nf++; $display("FAIL held_event_count got %0d want 1", evs);
    end
    drive(1, 1, 0, 8'h10, 16'h0400);
    tick();
    n++;
    if ({h0, e0, a0, v0} !== 6'b00_00_0_1) begin
      nf++; $display("FAIL held_release got %b want %b", {h0, e0, a0, v0}, 6'b00_00_0_1);
    end
  endtask

  task automatic test_overlap();
    drive(1, 1, 0, 8'h18, 16'h0800);
    tick();
    n++;
    if (h1[1] !== 1'b1 || {h1, e1, a1, v1} !== ex(1)) begin
      nf++; $display("FAIL overlap_hit got %b want %b", {h1, e1, a1, v1}, ex(1));
    end
    drive(1, 1, 0, 8'hFF, 16'h0000);
    tick();
    n++;
    if (h1[1] !== 1'b0 || {h1, e1, a1, v1} !== ex(1)) begin
      nf++; $display("FAIL overlap_absent got %b want %b", {h1, e1, a1, v1}, ex(1));
    end
  endtask

  task automatic test_clear_priority();
    drive(1, 1, 0, 8'h10, 16'h0010);
    tick();
    drive(1, 1, 1, 8'h10, 16'h0010);
    tick();
    n++;
    if ({h0, e0, a0, v0} !== 6'b0) begin
      nf++; $display("FAIL clear_priority got %b want %b", {h0, e0, a0, v0}, 6'b0);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 0, 8'h10, 16'h0010);
    tick();
    tick();
    drive(0, 0, 0, 8'h10, 16'h0010);
    tick();
    n++;
    if ({h0, e0, a0, v0, h1, e1, a1, v1} !== 12'h000) begin
      nf++; $display("FAIL reset_mid got %b want %b", {h0, e0, a0, v0, h1, e1, a1, v1}, 12'h000);
    end
    drive(1, 1, 0, 8'h10, 16'h0010);
    tick();
    n++;
    if ({h0, e0, a0, v0} !== 6'b01_01_1_1) begin
      nf++; $display("FAIL reset_first_event got %b want %b", {h0, e0, a0, v0}, 6'b01_01_1_1);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 0, 8'h22, k[0] ? 16'h2022 : 16'h0220);
      tick();
      n++;
      if ({h0, e0, a0, v0, h1, e1, a1, v1} !== {ex(0), ex(1)} || v0 !== 1'b1) begin
        nf++; $display("FAIL back_to_back %0d got %b want %b", k, {h0, e0, a0, v0, h1, e1, a1, v1}, {ex(0), ex(1)});
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [7:0] f, p[2];
      f = 8'($urandom);
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(3))
          0: p[j] = 8'h00;
          1: p[j] = f;
          2: p[j] = f & 8'($urandom);
          default: p[j] = 8'($urandom);
        endcase
      end
      drive($urandom_range(40) != 0, $urandom_range(1) == 1, $urandom_range(7) == 0, f, {p[1], p[0]});
      tick();
      n++;
      if ({h0, e0, a0, v0, h1, e1, a1, v1} !== {ex(0), ex(1)}) begin
        nf++; $display("FAIL random %0d got %b want %b", k, {h0, e0, a0, v0, h1, e1, a1, v1}, {ex(0), ex(1)});
      end
`ifdef POSCOMP_HITCOUNT_EN
      n++;
      if ({c0, c1} !== {ex_cnt(0)[3:0], ex_cnt(1)}) begin
        nf++; $display("FAIL random_count %0d got %h want %h", k, {c0, c1}, {ex_cnt(0)[3:0], ex_cnt(1)});
      end
`endif
    end
  endtask

`ifdef POSCOMP_HITCOUNT_EN
  task automatic test_count();
    drive(1, 0, 1, 8'h10, 16'h0010);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 0, 8'h10, 16'h0010);
      tick();
      drive(1, 1, 0, 8'h10, 16'h0000);
      tick();
    end
    n++;
    if (c0[1:0] !== 2'd3 || c0 !== ex_cnt(0)[3:0]) begin
      nf++; $display("FAIL count_saturate got %0d want 3", c0[1:0]);
    end
    drive(1, 0, 1, 8'h10, 16'h0010);
    tick();
    n++;
    if (c0 !== 4'd0) begin
      nf++; $display("FAIL count_clear got %0d want 0", c0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_exact_match();
    test_held();
    test_overlap();
    test_clear_priority();
    test_reset_mid();
    test_back_to_back();
`ifdef POSCOMP_HITCOUNT_EN
    test_count();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
